serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Nibble-serial 16-bit subtractor: A - B computed as A + ~B + 1, one nibble per
// BUSY cycle, with result flags registered on the final nibble.
module serial_subtractor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Z,
    output logic        borrow,
    output logic        zero,
    output logic        sign,
    output logic        parity,
    output logic        overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic [15:0] z_q, z_d;
    logic        borrow_q, borrow_d;
    logic        zero_q, zero_d;
    logic        sign_q, sign_d;
    logic        parity_q, parity_d;
    logic        overflow_q, overflow_d;

    logic [3:0]  a_nib, b_nib;
    logic [4:0]  nib_sum;
    logic [15:0] z_upd;

    always_comb begin
        a_nib   = a_q[{cnt_q, 2'b00} +: 4];
        b_nib   = b_q[{cnt_q, 2'b00} +: 4];
        nib_sum = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
        z_upd   = z_q;
        z_upd[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        z_d        = z_q;
        borrow_d   = borrow_q;
        zero_d     = zero_q;
        sign_d     = sign_q;
        parity_d   = parity_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = 2'd0;
                    carry_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                z_d     = z_upd;
                carry_d = nib_sum[4];
                cnt_d   = cnt_q + 2'd1;
                // Last nibble: flags see the fully assembled difference.
                if (cnt_q == 2'd3) begin
                    state_d    = DONE;
                    borrow_d   = ~nib_sum[4];
                    zero_d     = ~|z_upd;
                    sign_d     = z_upd[15];
                    parity_d   = ~^z_upd;
                    overflow_d = (a_q[15] & ~b_q[15] & ~z_upd[15]) |
                                 (~a_q[15] & b_q[15] & z_upd[15]);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            cnt_q      <= 2'd0;
            carry_q    <= 1'b0;
            z_q        <= 16'h0000;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b1;
            sign_q     <= 1'b0;
            parity_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            z_q        <= z_d;
            borrow_q   <= borrow_d;
            zero_q     <= zero_d;
            sign_q     <= sign_d;
            parity_q   <= parity_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Z         = z_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign sign      = sign_q;
    assign parity    = parity_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table through a scoreboard,
// plus backpressure and mid-operation reset sequences.
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Z;
    logic        borrow, zero, sign, parity, overflow;

    serial_subtractor dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .Z(Z), .borrow(borrow), .zero(zero), .sign(sign),
        .parity(parity), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] z;
        logic [4:0]  flags; // {borrow, zero, sign, parity, overflow}
    } vec_t;

    vec_t sb[$];
    vec_t tbl[12];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        logic [15:0] d;
        int ones;
        d = a - b;
        ones = $countones(d);
        v.a = a;
        v.b = b;
        v.z = d;
        v.flags = {(a < b), (d == 16'h0), d[15], (ones % 2 == 0),
                   ((a[15] != b[15]) && (d[15] != a[15]))};
        return v;
    endfunction

    function automatic vec_t lit(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] z, input logic [4:0] f);
        vec_t v;
        v.a = a; v.b = b; v.z = z; v.flags = f;
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_z"}, {16'h0, Z}, {16'h0, e.z});
            check({tag, "_flags"}, {27'h0, borrow, zero, sign, parity, overflow},
                  {27'h0, e.flags});
        end
    endtask

    // Drives one operation; returns with DUT in DONE (out_valid seen) or timed out.
    task automatic start_and_wait(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'h0, in_ready}, 1);
        A = v.a; B = v.b; in_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check({tag, "_busy_in_ready"}, {31'h0, in_ready}, 0);
        end
        check({tag, "_latency"}, lat, 4);
        check_outputs(tag);
    endtask

    task automatic finish_handshake(input string tag);
        @(posedge clk); #1;
        check({tag, "_idle_ret"}, {30'h0, in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        logic [15:0] z_hold;
        logic [4:0]  f_hold;
        vec_t        v;
        bit          stray;

        tbl[0] = lit(16'h0005, 16'h0003, 16'h0002, 5'b00000);
        tbl[1] = lit(16'h0003, 16'h0005, 16'hFFFE, 5'b10100);
        tbl[2] = lit(16'h8000, 16'h0001, 16'h7FFF, 5'b00001);
        tbl[3] = lit(16'h7FFF, 16'hFFFF, 16'h8000, 5'b10101);
        tbl[4] = lit(16'h1234, 16'h1234, 16'h0000, 5'b01010);
        tbl[5] = model(16'h0000, 16'h0001);
        tbl[6] = model(16'hFFFF, 16'h0000);
        tbl[7] = model(16'h0F0F, 16'h00F1);
        for (int i = 8; i < 12; i++) tbl[i] = model(16'($urandom), 16'($urandom));

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = 16'h0; B = 16'h0;
        #12;
        check("reset_ctrl", {30'h0, in_ready, out_valid}, 2'b10);
        check("reset_z", {16'h0, Z}, 32'h0);
        check("reset_flags", {27'h0, borrow, zero, sign, parity, overflow}, 5'b01010);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start_and_wait(tbl[i], $sformatf("vec%0d", i));
            finish_handshake($sformatf("vec%0d", i));
        end

        // Backpressure: results must hold and new operands must be ignored.
        out_ready = 1'b0;
        start_and_wait(model(16'hA5A5, 16'h5A5B), "bp");
        z_hold = Z;
        f_hold = {borrow, zero, sign, parity, overflow};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; A = 16'h1111; B = 16'h2222;
            @(posedge clk); #1;
            check("bp_hold_z", {16'h0, Z}, {16'h0, z_hold});
            check("bp_hold_flags", {27'h0, borrow, zero, sign, parity, overflow}, {27'h0, f_hold});
            check("bp_ctrl", {30'h0, in_ready, out_valid}, 2'b01);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        finish_handshake("bp");
        start_and_wait(model(16'h0100, 16'h0001), "post_bp");
        finish_handshake("post_bp");

        // Reset two edges after accept abandons the operation.
        @(negedge clk);
        A = 16'h4321; B = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl", {30'h0, in_ready, out_valid}, 2'b10);
        check("arst_z", {16'h0, Z}, 32'h0);
        check("arst_flags", {27'h0, borrow, zero, sign, parity, overflow}, 5'b01010);
        @(negedge clk); rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) stray = 1'b1;
        end
        check("arst_no_stale_valid", {31'h0, stray}, 0);
        start_and_wait(tbl[0], "post_rst");
        finish_handshake("post_rst");

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
